// File: rtl/adpll_grid_pkg.sv
// Shared encodings and the per-node coupling-weight rule for the ADPLL grid controller.
package adpll_grid_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RAMP   = 2'b01,
        ST_TRACK  = 2'b10,
        ST_LOCKED = 2'b11
    } state_e;

    localparam logic [1:0] MODE_PLL = 2'b00;
    localparam logic [1:0] MODE_BI  = 2'b01;
    localparam logic [1:0] MODE_UNI = 2'b10;

    localparam logic [3:0] W0 = 4'd0;
    localparam logic [3:0] W1 = 4'd1;
    localparam logic [3:0] W2 = 4'd2;
    localparam logic [3:0] W4 = 4'd4;

    // Returns {left, above, right, below}; node (0,0) treats the reference as its left neighbour.
    function automatic logic [15:0] node_weight(input logic [1:0] mode, input int row,
                                                input int col, input int rows, input int cols);
        logic       has_l, has_a, has_r, has_b;
        int         n_up, n_dn;
        logic [3:0] up_w, dn_w;
        has_l = (col > 0) || (row == 0);
        has_a = (row > 0);
        has_r = (col < cols - 1);
        has_b = (row < rows - 1);
        n_up  = 0;
        n_dn  = 0;
        if (has_l) n_up++;
        if (has_a) n_up++;
        if (has_r) n_dn++;
        if (has_b) n_dn++;
        up_w = W0;
        dn_w = W0;
        case (mode)
            MODE_UNI: up_w = (n_up == 2) ? W2 : W4;
            MODE_BI: begin
                if (n_dn == 0) begin
                    up_w = (n_up == 2) ? W2 : W4;
                end else begin
                    up_w = (n_up == 2) ? W1 : W2;
                    dn_w = (n_dn == 2) ? W1 : W2;
                end
            end
            default: return {W4, W0, W0, W0};
        endcase
        return {has_l ? up_w : W0, has_a ? up_w : W0, has_r ? dn_w : W0, has_b ? dn_w : W0};
    endfunction

endpackage

// File: rtl/adpll_grid_ctrl_node_lock_det.sv
// Per-node lock detector: |error| threshold test feeding a saturating in-lock run counter.
module node_lock_det #(
    parameter int PDET_WIDTH  = 5,
    parameter int LOCK_THRESH = 2,
    parameter int LOCK_CYCLES = 256
) (
    input  logic                  fpga_clk_i,
    input  logic                  reset_ni,
    input  logic                  clr_i,
    input  logic                  en_i,
    input  logic [PDET_WIDTH-1:0] error_i,
    output logic                  lock_o
);
    localparam int CNT_W = $clog2(LOCK_CYCLES + 1);

    logic [CNT_W-1:0]      r_cnt;
    logic [PDET_WIDTH-1:0] w_abs;
    logic                  w_most_neg;
    logic                  w_in_thr;

    // The most negative code has no positive twin, so it is rejected explicitly.
    assign w_most_neg = (error_i == {1'b1, {(PDET_WIDTH-1){1'b0}}});
    assign w_abs      = error_i[PDET_WIDTH-1] ? (~error_i + PDET_WIDTH'(1)) : error_i;
    assign w_in_thr   = !w_most_neg && (w_abs <= PDET_WIDTH'(LOCK_THRESH));

    always_ff @(posedge fpga_clk_i) begin
        if (!reset_ni || clr_i || !en_i || !w_in_thr) begin
            r_cnt <= '0;
        end else if (r_cnt != CNT_W'(LOCK_CYCLES)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign lock_o = (r_cnt == CNT_W'(LOCK_CYCLES));

endmodule

// File: rtl/adpll_grid_ctrl.sv
// ADPLL grid controller: staged node enable, coupling weights, config regs and lock FSM.
// Define ADPLL_LOCK_MON_EN to build per-node lock detection and the LOCKED state.
module adpll_grid_ctrl
    import adpll_grid_pkg::*;
#(
    parameter int ROWS        = 2,
    parameter int COLS        = 2,
    parameter int PDET_WIDTH  = 5,
    parameter int LOCK_THRESH = 2,
    parameter int LOCK_CYCLES = 256,
    parameter int RAMP_STEP   = 64
) (
    input  logic                             fpga_clk_i,
    input  logic                             reset_ni,
    input  logic                             enable_i,
    input  logic [1:0]                       mode_i,
    input  logic                             cfg_load_i,
    input  logic                             cfg_sel_i,
    input  logic [11:0]                      cfg_data_i,
    input  logic [ROWS*COLS*PDET_WIDTH-1:0]  error_i,
    output logic [ROWS*COLS-1:0]             node_en_o,
    output logic [ROWS*COLS*16-1:0]          weight_o,
    output logic [3:0]                       kp_o,
    output logic [3:0]                       ki_o,
    output logic [11:0]                      ref_sel_o,
    output logic [ROWS*COLS-1:0]             lock_o,
    output logic                             all_locked_o,
    output logic [1:0]                       state_o
);
    localparam int N      = ROWS * COLS;
    localparam int RCNT_W = $clog2(RAMP_STEP + 1);
    localparam logic [N*16-1:0] PLL_WEIGHTS = {N{{W4, W0, W0, W0}}};

    state_e            r_state, w_state_next;
    logic [1:0]        r_mode;
    logic [N-1:0]      r_node_en;
    logic [N-1:0]      w_lock;
    logic [RCNT_W-1:0] r_ramp_cnt;
    logic [N*16-1:0]   r_weight, w_weight_new;
    logic [3:0]        r_kp, r_ki;
    logic [11:0]       r_ref_sel;
    logic              w_mode_chg, w_load_mode, w_ramp_clr;

    genvar gi;

    assign w_mode_chg = (r_state != ST_IDLE) && (mode_i != r_mode);

    generate
        for (gi = 0; gi < N; gi++) begin : g_weight
            assign w_weight_new[gi*16 +: 16] = node_weight(mode_i, gi / COLS, gi % COLS, ROWS, COLS);
        end
    endgenerate

    always_ff @(posedge fpga_clk_i) begin
        if (!reset_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (!enable_i) begin
            w_state_next = ST_IDLE;
        end else if (r_state == ST_IDLE || w_mode_chg) begin
            w_state_next = ST_RAMP;
        end else begin
            case (r_state)
                ST_RAMP: if (r_node_en[N-1]) w_state_next = ST_TRACK;
                ST_TRACK: begin
`ifdef ADPLL_LOCK_MON_EN
                    if (&w_lock) w_state_next = ST_LOCKED;
`endif
                end
                ST_LOCKED: begin
`ifdef ADPLL_LOCK_MON_EN
                    if (!(&w_lock)) w_state_next = ST_TRACK;
`else
                    w_state_next = ST_TRACK;
`endif
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    // A (re)entry into RAMP latches the mode and restarts both the ramp and lock detection.
    always_comb begin
        w_load_mode  = 1'b0;
        w_ramp_clr   = 1'b0;
        if (!enable_i) begin
            w_ramp_clr = 1'b1;
        end else if (r_state == ST_IDLE || w_mode_chg) begin
            w_load_mode = 1'b1;
            w_ramp_clr  = 1'b1;
        end
        all_locked_o = (r_state == ST_LOCKED);
    end

    always_ff @(posedge fpga_clk_i) begin
        if (!reset_ni) begin
            r_mode     <= MODE_PLL;
            r_weight   <= PLL_WEIGHTS;
            r_node_en  <= '0;
            r_ramp_cnt <= '0;
        end else begin
            if (w_load_mode) begin
                r_mode   <= mode_i;
                r_weight <= w_weight_new;
            end
            if (w_ramp_clr) begin
                r_node_en  <= '0;
                r_ramp_cnt <= '0;
            end else if (r_state == ST_RAMP) begin
                if (r_ramp_cnt == RCNT_W'(RAMP_STEP - 1)) begin
                    r_ramp_cnt <= '0;
                    r_node_en  <= (r_node_en << 1) | N'(1);
                end else begin
                    r_ramp_cnt <= r_ramp_cnt + RCNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge fpga_clk_i) begin
        if (!reset_ni) begin
            r_kp      <= '0;
            r_ki      <= '0;
            r_ref_sel <= '0;
        end else if (cfg_load_i) begin
            if (cfg_sel_i) begin
                r_ref_sel <= cfg_data_i;
            end else begin
                r_kp <= cfg_data_i[11:8];
                r_ki <= cfg_data_i[3:0];
            end
        end
    end

`ifdef ADPLL_LOCK_MON_EN
    generate
        for (gi = 0; gi < N; gi++) begin : g_lock
            node_lock_det #(
                .PDET_WIDTH (PDET_WIDTH),
                .LOCK_THRESH(LOCK_THRESH),
                .LOCK_CYCLES(LOCK_CYCLES)
            ) u_lock_det (
                .fpga_clk_i(fpga_clk_i),
                .reset_ni  (reset_ni),
                .clr_i     (w_ramp_clr),
                .en_i      (r_node_en[gi]),
                .error_i   (error_i[gi*PDET_WIDTH +: PDET_WIDTH]),
                .lock_o    (w_lock[gi])
            );
        end
    endgenerate
`else
    logic w_unused_err;
    assign w_unused_err = ^error_i;
    assign w_lock       = '0;
`endif

    assign node_en_o = r_node_en;
    assign weight_o  = r_weight;
    assign kp_o      = r_kp;
    assign ki_o      = r_ki;
    assign ref_sel_o = r_ref_sel;
    assign lock_o    = w_lock;
    assign state_o   = r_state;

endmodule

// File: tb/tb_adpll_grid_ctrl.sv
// Self-checking bench for adpll_grid_ctrl: cycle-level behavioural model plus directed literal checks.
module tb_adpll_grid_ctrl;
    localparam int ROWS = 2, COLS = 2, N = 4, PW = 5, TH = 2, LC = 256, STEP = 64;
`ifdef ADPLL_LOCK_MON_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset_ni, enable, load, sel;
    logic [1:0]      mode;
    logic [11:0]     data;
    logic [N*PW-1:0] err;
    logic [N-1:0]    node_en_o, lock_o;
    logic [N*16-1:0] weight_o;
    logic [3:0]      kp_o, ki_o;
    logic [11:0]     ref_sel_o;
    logic            all_locked_o;
    logic [1:0]      state_o;

    adpll_grid_ctrl dut (
        .fpga_clk_i(clk), .reset_ni(reset_ni), .enable_i(enable), .mode_i(mode),
        .cfg_load_i(load), .cfg_sel_i(sel), .cfg_data_i(data), .error_i(err),
        .node_en_o(node_en_o), .weight_o(weight_o), .kp_o(kp_o), .ki_o(ki_o),
        .ref_sel_o(ref_sel_o), .lock_o(lock_o), .all_locked_o(all_locked_o), .state_o(state_o)
    );

    int n_cmp = 0, n_bad = 0;

    // Model: state 0..3, cycles since RAMP entry, per-node in-lock run length.
    int              m_state, m_t;
    logic [1:0]      m_mode;
    int              m_cnt[N];
    logic [3:0]      m_kp, m_ki;
    logic [11:0]     m_ref;
    logic [N*16-1:0] m_w;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] exp_weight(input logic [1:0] md, input int k);
        int r, c, nu, nd, ut, dt;
        bit up_l, up_a, dn_r, dn_b;
        r = k / COLS;
        c = k % COLS;
        if (md != 2'b01 && md != 2'b10) return 16'h4000;
        up_l = (c > 0) || (r == 0);
        up_a = (r > 0);
        dn_r = (c < COLS - 1);
        dn_b = (r < ROWS - 1);
        nu = int'(up_l) + int'(up_a);
        nd = int'(dn_r) + int'(dn_b);
        if (md == 2'b10 || nd == 0) begin ut = 4; dt = 0; end
        else begin ut = 2; dt = 2; end
        return {4'(up_l ? ut / nu : 0), 4'(up_a ? ut / nu : 0),
                4'(dn_r ? dt / nd : 0), 4'(dn_b ? dt / nd : 0)};
    endfunction

    function automatic logic [N-1:0] exp_en(input int st, input int t);
        logic [N-1:0] e;
        for (int k = 0; k < N; k++) e[k] = (st >= 2) || (st == 1 && t >= (k + 1) * STEP);
        return e;
    endfunction

    function automatic logic [N-1:0] exp_lock();
        logic [N-1:0] l;
        for (int k = 0; k < N; k++) l[k] = (m_cnt[k] == LC);
        return l;
    endfunction

    function automatic bit in_thr(input logic [PW-1:0] e);
        int v;
        v = int'($signed(e));
        return (v != -(1 << (PW - 1))) && (v >= -TH) && (v <= TH);
    endfunction

    task automatic model_step();
        logic [N-1:0] en0, lk0;
        bit chg;
        en0 = exp_en(m_state, m_t);
        lk0 = exp_lock();
        if (!reset_ni) begin
            m_state = 0; m_t = 0; m_mode = 2'b00; m_kp = 0; m_ki = 0; m_ref = 0;
            for (int k = 0; k < N; k++) begin m_cnt[k] = 0; m_w[k*16 +: 16] = 16'h4000; end
            return;
        end
        if (load) begin
            if (sel) m_ref = data;
            else begin m_kp = data[11:8]; m_ki = data[3:0]; end
        end
        chg = (m_state != 0) && (mode != m_mode);
        for (int k = 0; k < N; k++) begin
            if (LOCK_EN && enable && !chg && en0[k] && in_thr(err[k*PW +: PW]))
                m_cnt[k] = (m_cnt[k] < LC) ? m_cnt[k] + 1 : LC;
            else
                m_cnt[k] = 0;
        end
        if (!enable) begin
            m_state = 0; m_t = 0;
        end else if (m_state == 0 || chg) begin
            m_state = 1; m_t = 0; m_mode = mode;
            for (int k = 0; k < N; k++) m_w[k*16 +: 16] = exp_weight(mode, k);
        end else if (m_state == 1) begin
            if (en0[N-1]) m_state = 2; else m_t++;
        end else if (m_state == 2) begin
            if (&lk0) m_state = 3;
        end else begin
            if (!(&lk0)) m_state = 2;
        end
    endtask

    task automatic compare_all();
        chk("state", 64'(state_o), 64'(m_state));
        chk("node_en", 64'(node_en_o), 64'(exp_en(m_state, m_t)));
        chk("lock", 64'(lock_o), 64'(exp_lock()));
        chk("all_locked", 64'(all_locked_o), 64'(m_state == 3));
        chk("weight", 64'(weight_o), 64'(m_w));
        chk("kp_ki", 64'({kp_o, ki_o}), 64'({m_kp, m_ki}));
        chk("ref_sel", 64'(ref_sel_o), 64'(m_ref));
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            model_step();
            #1;
            compare_all();
        end
    endtask

    initial begin
        reset_ni = 1'b0; enable = 1'b0; mode = 2'b00; load = 1'b0; sel = 1'b0;
        data = '0; err = '0;
        ticks(3);
        chk("rst_state", 64'(state_o), 64'd0);
        chk("rst_en", 64'(node_en_o), 64'd0);
        chk("rst_w", 64'(weight_o), 64'h4000_4000_4000_4000);
        chk("rst_cfg", 64'({kp_o, ki_o, ref_sel_o}), 64'd0);
        reset_ni = 1'b1;
        ticks(2);

        enable = 1'b1;
        ticks(64);  chk("ramp_63", 64'(node_en_o), 64'b0000);
        ticks(1);   chk("ramp_64", 64'(node_en_o), 64'b0001);
        ticks(64);  chk("ramp_128", 64'(node_en_o), 64'b0011);
        ticks(64);  chk("ramp_192", 64'(node_en_o), 64'b0111);
        ticks(64);  chk("ramp_256", 64'(node_en_o), 64'b1111);
        chk("pll_w", 64'(weight_o), 64'h4000_4000_4000_4000);
        ticks(1);   chk("to_track", 64'(state_o), 64'd2);
        ticks(254); chk("lock_511", 64'(lock_o), LOCK_EN ? 64'b0111 : 64'b0000);
        ticks(1);   chk("lock_512", 64'(lock_o), LOCK_EN ? 64'b1111 : 64'b0000);
        ticks(1);   chk("to_locked", 64'(state_o), LOCK_EN ? 64'd3 : 64'd2);
        err[2*PW +: PW] = 5'd3;
        ticks(1);   chk("node2_drop", 64'(lock_o), LOCK_EN ? 64'b1011 : 64'b0000);
        err = '0;
        ticks(1);   chk("back_track", 64'(state_o), 64'd2);

        mode = 2'b01;
        ticks(1);   chk("mchg_en", 64'(node_en_o), 64'd0);
        chk("mchg_state", 64'(state_o), 64'd1);
        chk("bi_w", 64'(weight_o), 64'h2200_0220_2002_2011);
        ticks(9);
        load = 1'b1; sel = 1'b0; data = 12'h30A;
        ticks(1);   chk("cfg_kpki", 64'({kp_o, ki_o}), 64'h3A);
        sel = 1'b1; data = 12'hABC;
        ticks(1);   chk("cfg_ref", 64'(ref_sel_o), 64'hABC);
        load = 1'b0;
        ticks(52);  chk("ramp2_63", 64'(node_en_o), 64'b0000);
        ticks(1);   chk("ramp2_64", 64'(node_en_o), 64'b0001);

        mode = 2'b10;
        ticks(1);   chk("uni_w", 64'(weight_o), 64'h2200_0400_4000_4000);
        err[PW +: PW] = 5'b10000;
        ticks(600); chk("neg16_lock", 64'(lock_o), LOCK_EN ? 64'b1101 : 64'b0000);
        chk("neg16_state", 64'(state_o), 64'd2);
        enable = 1'b0; err = '0;
        ticks(1);   chk("dis_state", 64'(state_o), 64'd0);
        chk("dis_en", 64'(node_en_o), 64'd0);
        enable = 1'b1; mode = 2'b11;
        ticks(1);   chk("m11_w", 64'(weight_o), 64'h4000_4000_4000_4000);

        for (int cyc = 0; cyc < 20000; cyc++) begin
            reset_ni = ($urandom_range(0, 4999) != 0);
            if (enable) enable = ($urandom_range(0, 2999) != 0);
            else        enable = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 1999) == 0) mode = 2'($urandom_range(0, 3));
            load = ($urandom_range(0, 49) == 0);
            sel  = 1'($urandom_range(0, 1));
            data = 12'($urandom);
            for (int k = 0; k < N; k++) begin
                int v;
                if ($urandom_range(0, 399) == 0) v = int'($urandom_range(0, 31));
                else v = int'($urandom_range(0, 4)) - 2;
                err[k*PW +: PW] = v[PW-1:0];
            end
            ticks(1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
